fetch_ctrl: RTL

//  Sequences the byte-wide flash and the program_counter to fetch 32-bit instructions for the control unit.

---
 rtl/fetch_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: reads four flash bytes at the PC (stepping the PC once per
// byte), assembles them little-endian into inst, and hands the word to decode via
// inst_valid/inst_ready. It also owns the flash write port: a programming request writes a
// 32-bit word as four sequential byte writes.
// Ports:
//   clk, reset (async, active-low)
//   fetch_en              : level, fetch while high
//   pc_in / pc_control    : program counter value / 00 hold, 01 increment
//   flash_addr/re/we/in   : flash byte address, read enable, write enable, write data
//   flash_out             : flash read data, READ_LAT cycles after the read is issued
//   inst, inst_valid      : assembled instruction and its handshake valid
//   inst_ready            : decode accepts inst (only looked at in HOLD)
//   prog_req/addr/data    : programming request (level) with byte address and word
//   prog_ack              : one-cycle pulse when the write sequence completes
//   busy                  : high whenever not idle
module fetch_ctrl #(
   parameter int READ_LAT = 3,
   parameter int ADDR_W   = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [1:0]        pc_control,
   output logic [ADDR_W-1:0] flash_addr,
   output logic              flash_re,
   output logic              flash_we,
   output logic [7:0]        flash_in,
   input  logic [7:0]        flash_out,
   output logic [31:0]       inst,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              prog_req,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [31:0]       prog_data,
   output logic              prog_ack,
   output logic              busy
);

   localparam int CNT_W = $clog2(READ_LAT + 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      PC_INC,
      PC_SETTLE,
      HOLD,
      WR_BYTE,
      WR_DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [1:0]        byte_idx;
   logic [1:0]        byte_idx_nx;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nx;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [31:0]       inst_q;
   logic              rd_last;

   // Last wait cycle: flash_out is valid now and is captured on this edge.
   assign rd_last = (state == RD_WAIT) && (cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         byte_idx <= '0;
         cnt      <= '0;
         rd_addr  <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         inst_q   <= '0;
      end else begin
         state    <= state_nx;
         byte_idx <= byte_idx_nx;
         cnt      <= cnt_nx;
         // Hold the read address for the whole wait, whatever pc_in does.
         if (state == RD_ISSUE)
            rd_addr <= pc_in;
         if (state == IDLE && prog_req) begin
            wr_addr <= prog_addr;
            wr_data <= prog_data;
         end
         if (rd_last)
            inst_q[8*byte_idx +: 8] <= flash_out;
      end
   end

   always_comb begin
      state_nx    = state;
      byte_idx_nx = byte_idx;
      cnt_nx      = cnt;
      pc_control  = 2'b00;
      flash_addr  = '0;
      flash_re    = 1'b0;
      flash_we    = 1'b0;
      flash_in    = 8'h00;
      inst_valid  = 1'b0;
      prog_ack    = 1'b0;
      unique case (state)
         IDLE: begin
            if (prog_req) begin
               state_nx    = WR_BYTE;
               byte_idx_nx = 2'd0;
            end else if (fetch_en) begin
               state_nx    = RD_ISSUE;
               byte_idx_nx = 2'd0;
            end
         end
         RD_ISSUE: begin
            flash_addr = pc_in;
            flash_re   = 1'b1;
            cnt_nx     = CNT_W'(READ_LAT);
            state_nx   = RD_WAIT;
         end
         RD_WAIT: begin
            flash_addr = rd_addr;
            flash_re   = 1'b1;
            cnt_nx     = cnt - CNT_W'(1);
            if (rd_last)
               state_nx = PC_INC;
         end
         PC_INC: begin
            pc_control = 2'b01;
            state_nx   = PC_SETTLE;
         end
         PC_SETTLE: begin
            if (byte_idx == 2'd3) begin
               state_nx = HOLD;
            end else begin
               byte_idx_nx = byte_idx + 2'd1;
               state_nx    = RD_ISSUE;
            end
         end
         HOLD: begin
            inst_valid = 1'b1;
            if (inst_ready)
               state_nx = IDLE;
         end
         WR_BYTE: begin
            flash_we   = 1'b1;
            flash_addr = wr_addr + ADDR_W'(byte_idx);
            flash_in   = wr_data[8*byte_idx +: 8];
            if (byte_idx == 2'd3)
               state_nx = WR_DONE;
            else
               byte_idx_nx = byte_idx + 2'd1;
         end
         WR_DONE: begin
            prog_ack = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign inst = inst_q;
   assign busy = (state != IDLE);

endmodule
